// File: rtl/fir_pkg.sv
// Shared types and constants for the 21-tap symmetric FIR coefficient path.
// Holds the coefficient type, the power-on coefficient set and the loader states.
package fir_pkg;
    localparam int NUM_COEFF = 11;
    localparam int COEFF_W   = 18;
    localparam int IDX_W     = $clog2(NUM_COEFF);
    localparam int BANK_W    = NUM_COEFF * COEFF_W;

    typedef logic signed [COEFF_W-1:0] coeff_t;
    typedef logic [IDX_W-1:0]          idx_t;

    localparam idx_t IDX_LAST = idx_t'(NUM_COEFF - 1);
    localparam idx_t IDX_ZERO = idx_t'(32'd0);
    localparam idx_t IDX_ONE  = idx_t'(32'd1);

    // b[0] first; the centre tap b[10] is the largest.
    localparam coeff_t DEFAULT_COEFF [NUM_COEFF] = '{
        18'sd4094,   18'sd5900,   18'sd3326,  -18'sd3449,
        -18'sd10679, -18'sd12462, -18'sd4029,  18'sd14915,
        18'sd38991,  18'sd59143,  18'sd66990
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2,
        ARMED = 2'd3
    } state_t;

    function automatic coeff_t bank_coeff(input logic [BANK_W-1:0] bank, input int k);
        return coeff_t'(bank[k*COEFF_W +: COEFF_W]);
    endfunction
endpackage

// File: rtl/coeff_bank.sv
// NUM_COEFF x COEFF_W coefficient register bank with indexed write and
// whole-bank parallel load; resets to zero or to the package default set.
module coeff_bank
    import fir_pkg::*;
#(
    parameter bit USE_DEFAULT = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  idx_t              wr_idx,
    input  coeff_t            wr_data,
    input  logic              load_en,
    input  logic [BANK_W-1:0] load_bank,
    output logic [BANK_W-1:0] bank
);
    coeff_t bank_r [NUM_COEFF];

    // Bank storage: parallel load has priority over a single-word write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                bank_r[i] <= USE_DEFAULT ? DEFAULT_COEFF[i] : coeff_t'({COEFF_W{1'b0}});
            end
        end else if (load_en) begin
            for (int i = 0; i < NUM_COEFF; i++) begin
                bank_r[i] <= coeff_t'(load_bank[i*COEFF_W +: COEFF_W]);
            end
        end else if (wr_en && (wr_idx <= IDX_LAST)) begin
            bank_r[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_COEFF; g++) begin : g_flat
        assign bank[g*COEFF_W +: COEFF_W] = bank_r[g];
    end
endmodule

// File: rtl/fir_coeff_loader.sv
// Run-time coefficient loader: fills a shadow bank over valid/ready and swaps it
// into the active bank atomically on a sample_tick after commit.
module fir_coeff_loader
    import fir_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_tick,
    input  logic                load_start,
    input  logic                c_valid,
    input  logic signed [COEFF_W-1:0] c_data,
    output logic                c_ready,
    input  logic                commit,
    input  logic                abort,
    output logic [BANK_W-1:0]   coeff_out,
    output logic                swap_pulse,
    output logic                busy,
    output logic                err
);
    state_t state_r, state_s;
    idx_t   idx_r, idx_s;
    logic   err_r, err_s;
    logic   swap_pulse_r, swap_s;
    logic   busy_r;
    logic   wr_en_s, load_en_s;
    logic [BANK_W-1:0] shadow_s;

    assign c_ready = (state_r == LOAD);

    // Next-state, index, error and bank-control decode; abort outranks everything.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        err_s     = err_r;
        swap_s    = 1'b0;
        wr_en_s   = 1'b0;
        load_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_start) begin
                    state_s = LOAD;
                    idx_s   = IDX_ZERO;
                    err_s   = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_s = IDLE;
                end else if (load_start) begin
                    idx_s = IDX_ZERO;
                end else begin
                    if (commit) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                    if (c_valid) begin
                        wr_en_s = 1'b1;
                        if (idx_r == IDX_LAST) begin
                            state_s = FULL;
                        end else begin
                            idx_s = idx_r + IDX_ONE;
                        end
                    end else begin
                        wr_en_s = 1'b0;
                    end
                end
            end
            FULL: begin
                if (abort) begin
                    state_s = IDLE;
                end else begin
                    if (commit) begin
                        state_s = ARMED;
                    end else begin
                        state_s = FULL;
                    end
                    if (c_valid) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = err_r;
                    end
                end
            end
            ARMED: begin
                // The commit cycle itself was spent in FULL, so any tick here is strictly later.
                if (abort) begin
                    state_s = IDLE;
                end else if (sample_tick) begin
                    state_s   = IDLE;
                    load_en_s = 1'b1;
                    swap_s    = 1'b1;
                end else begin
                    state_s = ARMED;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= IDX_ZERO;
            err_r        <= 1'b0;
            swap_pulse_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            err_r        <= err_s;
            swap_pulse_r <= swap_s;
            busy_r       <= (state_s != IDLE);
        end
    end

    coeff_bank #(.USE_DEFAULT(1'b0)) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en_s),
        .wr_idx    (idx_r),
        .wr_data   (c_data),
        .load_en   (1'b0),
        .load_bank ({BANK_W{1'b0}}),
        .bank      (shadow_s)
    );

    coeff_bank #(.USE_DEFAULT(1'b1)) u_active (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (1'b0),
        .wr_idx    (IDX_ZERO),
        .wr_data   (coeff_t'({COEFF_W{1'b0}})),
        .load_en   (load_en_s),
        .load_bank (shadow_s),
        .bank      (coeff_out)
    );

    assign swap_pulse = swap_pulse_r;
    assign busy       = busy_r;
    assign err        = err_r;
endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader.
module tb_fir_coeff_loader;
    import fir_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              sample_tick = 1'b0;
    logic              load_start = 1'b0;
    logic              c_valid = 1'b0;
    logic signed [COEFF_W-1:0] c_data = '0;
    logic              c_ready;
    logic              commit = 1'b0;
    logic              abort = 1'b0;
    logic [BANK_W-1:0] coeff_out;
    logic              swap_pulse;
    logic              busy;
    logic              err;

    int total = 0;
    int bad   = 0;
    logic [BANK_W-1:0] def_flat;
    logic [BANK_W-1:0] exp_act;

    fir_coeff_loader dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .load_start  (load_start),
        .c_valid     (c_valid),
        .c_data      (c_data),
        .c_ready     (c_ready),
        .commit      (commit),
        .abort       (abort),
        .coeff_out   (coeff_out),
        .swap_pulse  (swap_pulse),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BANK_W-1:0] got, input logic [BANK_W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic ls, input logic cv, input int cd,
                       input logic cm, input logic ab, input logic st);
        load_start  = ls;
        c_valid     = cv;
        c_data      = coeff_t'(cd);
        commit      = cm;
        abort       = ab;
        sample_tick = st;
        step();
        load_start  = 1'b0;
        c_valid     = 1'b0;
        commit      = 1'b0;
        abort       = 1'b0;
        sample_tick = 1'b0;
    endtask

    function automatic logic [BANK_W-1:0] flat_seq(input int base);
        logic [BANK_W-1:0] f;
        for (int k = 0; k < NUM_COEFF; k++) f[k*COEFF_W +: COEFF_W] = coeff_t'(base + k);
        return f;
    endfunction

    task automatic load_words(input int base);
        for (int k = 0; k < NUM_COEFF; k++) drv(1'b0, 1'b1, base + k, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        exp_act = def_flat;
    endtask

    initial begin
        def_flat = {
            18'sd66990, 18'sd59143, 18'sd38991, 18'sd14915, -18'sd4029, -18'sd12462,
            -18'sd10679, -18'sd3449, 18'sd3326, 18'sd5900, 18'sd4094
        };

        // Reset release
        do_reset();
        step();
        check("rst_coeff", coeff_out, def_flat);
        check("rst_b10", BANK_W'(bank_coeff(coeff_out, 10)), BANK_W'(18'sd66990));
        check("rst_b3", BANK_W'(bank_coeff(coeff_out, 3)), BANK_W'(-18'sd3449));
        check("rst_busy", BANK_W'(busy), BANK_W'(1'b0));
        check("rst_err", BANK_W'(err), BANK_W'(1'b0));
        check("rst_ready", BANK_W'(c_ready), BANK_W'(1'b0));

        // Full load of 1..11
        drv(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("ld_ready", BANK_W'(c_ready), BANK_W'(1'b1));
        check("ld_busy", BANK_W'(busy), BANK_W'(1'b1));
        load_words(1);
        check("ld_ready_full", BANK_W'(c_ready), BANK_W'(1'b0));
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("ld_pre_tick", coeff_out, def_flat);
        check("ld_no_pulse", BANK_W'(swap_pulse), BANK_W'(1'b0));
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        exp_act = flat_seq(1);
        check("ld_swap", coeff_out, exp_act);
        check("ld_pulse", BANK_W'(swap_pulse), BANK_W'(1'b1));
        check("ld_busy_done", BANK_W'(busy), BANK_W'(1'b0));
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("ld_pulse_one", BANK_W'(swap_pulse), BANK_W'(1'b0));

        // Gapped words, then a 12th word offered in FULL
        drv(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 33; i++) begin
            drv(1'b0, (i % 3) == 0, -200 + i / 3, 1'b0, 1'b0, 1'b0);
        end
        check("gap_ready_full", BANK_W'(c_ready), BANK_W'(1'b0));
        drv(1'b0, 1'b1, 999, 1'b0, 1'b0, 1'b0);
        check("gap_err", BANK_W'(err), BANK_W'(1'b1));
        check("gap_act_kept", coeff_out, exp_act);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        exp_act = flat_seq(-200);
        check("gap_swap", coeff_out, exp_act);
        check("gap_err_sticky", BANK_W'(err), BANK_W'(1'b1));

        // Early commit after 4 words
        drv(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        check("ec_err_clr", BANK_W'(err), BANK_W'(1'b0));
        for (int k = 0; k < 4; k++) drv(1'b0, 1'b1, 50 + k, 1'b0, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("ec_err", BANK_W'(err), BANK_W'(1'b1));
        check("ec_still_load", BANK_W'(c_ready), BANK_W'(1'b1));
        for (int k = 4; k < NUM_COEFF; k++) drv(1'b0, 1'b1, 50 + k, 1'b0, 1'b0, 1'b0);
        check("ec_full", BANK_W'(c_ready), BANK_W'(1'b0));
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        exp_act = flat_seq(50);
        check("ec_swap", coeff_out, exp_act);
        check("ec_pulse", BANK_W'(swap_pulse), BANK_W'(1'b1));

        // Abort racing a sample tick in ARMED
        do_reset();
        drv(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        load_words(7000);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        drv(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        check("ab_no_pulse", BANK_W'(swap_pulse), BANK_W'(1'b0));
        check("ab_coeff", coeff_out, def_flat);
        check("ab_busy", BANK_W'(busy), BANK_W'(1'b0));
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("ab_idle_tick", coeff_out, def_flat);

        // Commit coinciding with a tick waits for the next tick
        drv(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        load_words(300);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b1);
        check("ct_no_pulse", BANK_W'(swap_pulse), BANK_W'(1'b0));
        check("ct_coeff", coeff_out, def_flat);
        check("ct_busy", BANK_W'(busy), BANK_W'(1'b1));
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        exp_act = flat_seq(300);
        check("ct_swap", coeff_out, exp_act);
        check("ct_pulse", BANK_W'(swap_pulse), BANK_W'(1'b1));

        // Asynchronous reset while ARMED
        drv(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        load_words(400);
        drv(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        check("ar_armed", coeff_out, exp_act);
        reset = 1'b1;
        #2;
        check("ar_coeff", coeff_out, def_flat);
        check("ar_busy", BANK_W'(busy), BANK_W'(1'b0));
        step();
        reset = 1'b0;
        drv(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        check("ar_no_swap", coeff_out, def_flat);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
- Run-time coefficient configuration controller for the 21-tap symmetric FIR, which uses 11 unique 0s18 coefficients b[0..10].
- A host streams a new coefficient set into a shadow bank over a valid/ready handshake, then commits it.
- The controller swaps the shadow bank into the active bank atomically on a sample boundary, so the filter never computes with a mixed set.
- Sits between the host/config interface and the FIR coefficient inputs.

Parameters:
- NUM_COEFF, 11, number of unique coefficients (symmetric half plus centre)
- COEFF_W, 18, coefficient width, signed 0s18

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sample_tick  in  1  one-cycle pulse marking the FIR sample boundary; a swap may occur only here
- load_start  in  1  pulse: begin a new load sequence
- c_valid  in  1  coefficient word valid
- c_data  in  COEFF_W  signed coefficient; word k goes to b[k], in order k=0..NUM_COEFF-1
- c_ready  out  1  controller accepts c_data this cycle
- commit  in  1  pulse: request swap of a fully loaded shadow bank
- abort  in  1  pulse: discard the load in progress
- coeff_out  out  NUM_COEFF*COEFF_W  active bank, flattened; b[0] in bits [COEFF_W-1:0]
- swap_pulse  out  1  high for exactly one cycle, the first cycle the new coeff_out is visible
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky protocol error flag

Behaviour:
- Reset, asynchronous:
  - state=IDLE, write index=0, shadow bank=0.
  - Active bank = default set: 4094, 5900, 3326, -3449, -10679, -12462, -4029, 14915, 38991, 59143, 66990.
  - c_ready=0, swap_pulse=0, busy=0, err=0.
- States: IDLE, LOAD, FULL, ARMED. All outputs registered except c_ready, which equals (state==LOAD).
- IDLE:
  - load_start -> LOAD; index=0; err cleared.
  - commit, abort and c_valid are ignored.
- LOAD:
  - Each cycle with c_valid && c_ready writes shadow[index] and increments index.
  - The write of index NUM_COEFF-1 moves to FULL on the same edge.
  - commit in LOAD sets err; the state is unchanged.
  - load_start in LOAD restarts: index=0; shadow contents are not cleared.
- FULL:
  - c_ready=0. c_valid in FULL sets err; the data is dropped.
  - commit -> ARMED.
- ARMED:
  - On the first sample_tick strictly after the commit cycle, the active bank takes the shadow bank, state -> IDLE, and swap_pulse is asserted in the following cycle together with the new coeff_out.
  - A sample_tick in the same cycle as commit does not swap.
- Abort:
  - abort in LOAD, FULL or ARMED -> IDLE; the active bank is untouched.
  - abort together with sample_tick in ARMED: abort wins, no swap.
  - abort has priority over commit and load_start in the same cycle.
- load_start outside IDLE and LOAD is ignored.
- Swap latency: sample_tick at edge N gives the new coeff_out and swap_pulse=1 in cycle N+1.
- Reset mid-load or while ARMED: the active bank returns to the default set and the partial shadow bank is lost.
- The index is sized as clog2(NUM_COEFF) bits and never wraps; it saturates logically via the FULL transition.
- Signed data is passed through unmodified; no scaling or saturation is applied.

Decomposition:
- Shared package fir_pkg holds:
  - NUM_COEFF and COEFF_W
  - the coefficient type (signed [COEFF_W-1:0])
  - the default coefficient constant array
  - the state enum (IDLE, LOAD, FULL, ARMED)
- One sub-module, coeff_bank: NUM_COEFF x COEFF_W register array with indexed write, parallel load from a second bank, and async reset to the package default. It is instantiated twice (shadow with zero default, active with the package default) via a use-default parameter.

Test Plan:
- Reset release: coeff_out equals the default set (b[10]=66990, b[3]=-3449); busy=0, err=0, c_ready=0.
- Full load: load_start, then 11 words 1..11 with c_valid held high, commit, sample_tick 5 cycles later. Required: c_ready low after the 11th word; coeff_out unchanged until the tick; one cycle after the tick, b[k]=k+1 and swap_pulse=1 for one cycle; busy=0.
- Backpressure and gaps: words presented with c_valid toggling (e.g. every third cycle), and a 12th word offered in FULL. Required: exactly 11 words captured in order; the 12th word sets err=1 and active is unaffected.
- Early commit: commit after 4 words. Required: err=1, state stays LOAD, remaining 7 words are accepted, then commit plus tick swaps normally.
- Abort race: in ARMED, assert abort and sample_tick in the same cycle. Required: no swap_pulse, coeff_out stays at the defaults, busy=0 next cycle.
- Commit/tick coincidence and async reset: commit in the same cycle as sample_tick -> no swap until the next tick. Asserting reset while ARMED -> coeff_out returns to the defaults immediately, without waiting for a clock edge.
